// File: rtl/key_scan_repeat.sv
// Push-button front-end: 2-flop sync, per-key debounce, single-key arbitration and hold-to-repeat.
// Define KEY_REPEAT_ACCEL_EN to shorten the repeat interval to REPEAT_RATE/4 after 8 repeats.
module key_scan_repeat #(
   parameter int unsigned       N_KEYS       = 6,
   parameter int unsigned       DEBOUNCE_CYC = 20,
   parameter int unsigned       REPEAT_DELAY = 500,
   parameter int unsigned       REPEAT_RATE  = 200,
   parameter logic [N_KEYS-1:0] REPEAT_MASK  = 6'b111100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_held,
   output logic [N_KEYS-1:0] key_evt,
   output logic              lockout
);

   localparam int unsigned DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam int unsigned IDX_W   = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
`ifdef KEY_REPEAT_ACCEL_EN
   localparam int unsigned ACC_RATE = (REPEAT_RATE / 4 >= 1) ? REPEAT_RATE / 4 : 1;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StDelay,
      StRepeat,
      StLockout,
      StWaitRel
   } state_e;

   logic [N_KEYS-1:0]            sync1_q, sync2_q;
   logic [N_KEYS-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [N_KEYS-1:0]            held_q, held_d;
   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [RPT_W-1:0]             rpt_cnt_q, rpt_cnt_d;
   logic [N_KEYS-1:0]            evt_q, evt_d;
`ifdef KEY_REPEAT_ACCEL_EN
   logic [3:0]                   acc_q, acc_d;
`endif

   logic                         held_one_hot;
   logic [IDX_W-1:0]             held_idx;
   logic [N_KEYS-1:0]            idx_mask;
   logic                         own_held, other_held;
   logic [RPT_W-1:0]             rate_last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
      end
   end

   // Counter measures how long the synced level has disagreed with the debounced level.
   always_comb begin
      held_d   = held_q;
      db_cnt_d = '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
         if (sync2_q[k] != held_q[k]) begin
            if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
               held_d[k] = ~held_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      held_one_hot = (held_q != '0) && ((held_q & (held_q - N_KEYS'(1))) == '0);
      held_idx     = '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
         if (held_q[k]) begin
            held_idx = IDX_W'(k);
         end
      end
      idx_mask   = N_KEYS'(1) << idx_q;
      own_held   = |(held_q & idx_mask);
      other_held = |(held_q & ~idx_mask);
`ifdef KEY_REPEAT_ACCEL_EN
      rate_last  = (acc_q >= 4'd8) ? RPT_W'(ACC_RATE - 1) : RPT_W'(REPEAT_RATE - 1);
`else
      rate_last  = RPT_W'(REPEAT_RATE - 1);
`endif
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rpt_cnt_d = rpt_cnt_q;
      evt_d     = '0;
`ifdef KEY_REPEAT_ACCEL_EN
      acc_d     = acc_q;
`endif
      case (state_q)
         StIdle: begin
            if (held_one_hot) begin
               evt_d     = held_q;
               idx_d     = held_idx;
               rpt_cnt_d = '0;
               state_d   = REPEAT_MASK[held_idx] ? StDelay : StWaitRel;
            end else if (held_q != '0) begin
               state_d = StLockout;
            end
         end
         // Release is checked first so it beats a coincident terminal count.
         StDelay: begin
            if (!own_held) begin
               state_d = StIdle;
            end else if (other_held) begin
               state_d = StLockout;
            end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
               evt_d     = idx_mask;
               rpt_cnt_d = '0;
               state_d   = StRepeat;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
         end
         StRepeat: begin
            if (!own_held) begin
               state_d = StIdle;
            end else if (other_held) begin
               state_d = StLockout;
            end else if (rpt_cnt_q == rate_last) begin
               evt_d     = idx_mask;
               rpt_cnt_d = '0;
`ifdef KEY_REPEAT_ACCEL_EN
               if (acc_q < 4'd8) begin
                  acc_d = acc_q + 4'd1;
               end
`endif
            end else begin
               rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
         end
         StWaitRel: begin
            if (!own_held) begin
               state_d = StIdle;
            end else if (other_held) begin
               state_d = StLockout;
            end
         end
         StLockout: begin
            if (held_q == '0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
`ifdef KEY_REPEAT_ACCEL_EN
      if (state_d != StRepeat) begin
         acc_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         db_cnt_q  <= '0;
         held_q    <= '0;
         state_q   <= StIdle;
         idx_q     <= '0;
         rpt_cnt_q <= '0;
         evt_q     <= '0;
`ifdef KEY_REPEAT_ACCEL_EN
         acc_q     <= '0;
`endif
      end else begin
         db_cnt_q  <= db_cnt_d;
         held_q    <= held_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         rpt_cnt_q <= rpt_cnt_d;
         evt_q     <= evt_d;
`ifdef KEY_REPEAT_ACCEL_EN
         acc_q     <= acc_d;
`endif
      end
   end

   assign key_held = held_q;
   assign key_evt  = evt_q;
   assign lockout  = (state_q == StLockout);

endmodule

// File: doc/key_scan_repeat.md
Name: key_scan_repeat

Overview:
Upstream front-end for the alarm-clock top level. Takes the six raw push-button lines, then synchronises, debounces and arbitrates them. Emits single-cycle one-hot key events, with hold-to-repeat on the adjust keys. The clock/alarm core consumes `key_evt` directly, so it no longer needs its own hold counter.

Parameters:
- N_KEYS, 6, number of key lines.
- DEBOUNCE_CYC, 20, consecutive stable samples required (20 ms at 1 kHz clk).
- REPEAT_DELAY, 500, cycles from first event to first repeat event.
- REPEAT_RATE, 200, cycles between subsequent repeat events.
- REPEAT_MASK, 6'b111100, keys allowed to auto-repeat (MIN/SEC inc/dec). Mode and alarm-toggle keys never repeat.

Ports:
- clk, input, 1, system clock (1 kHz tick domain).
- reset, input, 1, synchronous, active-low.
- key_raw, input, N_KEYS, asynchronous button levels, active-high.
- key_held, output, N_KEYS, debounced key levels.
- key_evt, output, N_KEYS, one-hot event pulse, exactly one cycle wide.
- lockout, output, 1, high while a multi-key press is being ignored.

Behaviour:
- **Reset** (reset==0 at posedge clk): sync flops, debounce counters, key_held, key_evt, lockout and repeat counter all clear to 0. FSM goes to IDLE.
- **Synchroniser:** two-flop synchroniser per key.
- **Debounce (per key):**
  - Counter resets whenever the synced sample equals key_held.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, key_held toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes key_held.
- **Latency:**
  - key_held follows a stable raw edge 2+DEBOUNCE_CYC cycles later.
  - key_evt pulses one cycle after key_held rises.
- **FSM states:** IDLE, DELAY, REPEAT, LOCKOUT, WAIT_REL.
  - **IDLE:**
    - Exactly one key_held bit set → pulse key_evt for that key. Latch the key index and clear the repeat counter. Go to DELAY if the key is in REPEAT_MASK, else WAIT_REL.
    - More than one bit set → LOCKOUT, no event.
  - **DELAY:**
    - Repeat counter counts to REPEAT_DELAY-1, then pulses key_evt for the latched key and goes to REPEAT.
    - Latched key released → IDLE.
    - Any other key held → LOCKOUT.
  - **REPEAT:** pulses key_evt every REPEAT_RATE cycles. Release and second-key rules are the same as DELAY.
  - **WAIT_REL:**
    - Latched key released → IDLE.
    - Another key held → LOCKOUT.
  - **LOCKOUT:**
    - lockout=1, no events.
    - Returns to IDLE one cycle after key_held==0.
- **Release:** release never generates an event. key_evt is never multi-hot.
- **Simultaneous events:**
  - Release and repeat-terminal-count in the same cycle: release wins, no event.
  - Two keys debounce high in the same cycle: LOCKOUT.
- **Counter widths:**
  - Debounce counter: $clog2(DEBOUNCE_CYC) bits.
  - Repeat counter: $clog2(max(REPEAT_DELAY, REPEAT_RATE)) bits.
  - No wrap: counters saturate or clear only as described above.
- **Mid-operation reset:** synchronous reset mid-hold clears everything. A key still held after reset must be re-debounced, then produces a fresh first event.

Optional Feature:
- Macro: KEY_REPEAT_ACCEL_EN.
- When defined:
  - A 4-bit repeat-event counter runs in REPEAT, saturating at 8.
  - After 8 repeat events the interval becomes REPEAT_RATE/4 (integer, minimum 1) until release.
  - The counter clears on leaving REPEAT.
- When undefined: the interval is always REPEAT_RATE, and the counter logic is absent.

Test Plan:
1. **Reset values:** hold reset=0 for 5 cycles with key_raw=6'b111111 → key_held=0, key_evt=0, lockout=0 throughout.
2. **Single press, no repeat key:** key_raw=6'b000010 stable for 1000 cycles → key_held[1] rises at cycle 22. key_evt=6'b000010 is exactly one pulse at cycle 23, with no further events.
3. **Repeat key:** key_raw=6'b100000 held 1200 cycles → events at cycles 23, 523, 723, 923, 1123. Release adds no event.
4. **Glitch rejection:** key_raw[4] high for 15 cycles then low → key_held and key_evt stay 0.
5. **Multi-key lockout:** hold key 5 through its first event, then add key 2 → lockout=1, no further events. Release both → lockout drops after key_held==0, and the next single press works normally.
6. **Acceleration (KEY_REPEAT_ACCEL_EN):** hold key 3 → after the 8th repeat event, spacing drops from 200 to 50 cycles. Without the macro, spacing stays 200.
